// File: rtl/ula_video_timing.sv
// ula_video_timing
//   Frame timing generator for the ULA video path. A horizontal and a vertical
//   counter run at the 7 MHz pixel rate and are decoded into sync, blanking,
//   display-enable, the Z80 frame interrupt and the FLASH phase. It also forms
//   the 13-bit bitmap and attribute offsets (relative to 0x4000) for the
//   current pixel cell.
//
// Ports
//   clock     pixel clock; all state changes on the falling edge
//   reset     synchronous, active-high; has priority over ce
//   ce        count enable; when low every register holds
//   hc, vc    horizontal / vertical count
//   hsync_n   horizontal sync, active low
//   vsync_n   vertical sync, active low
//   blank     horizontal or vertical blanking
//   disp_en   inside the 256x192 active area
//   int_n     Z80 /INT, active low, INT_LEN pixel clocks at the start of line 248
//   flash     FLASH attribute phase (bit 4 of the frame counter)
//   bmp_addr  bitmap offset, meaningful while disp_en=1
//   att_addr  attribute offset, meaningful while disp_en=1

module ula_video_timing #(
    parameter int H_TOTAL  = 448,
    parameter int V_TOTAL  = 312,
    parameter int HS_START = 320,
    parameter int HS_END   = 351,
    parameter int INT_LEN  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    output logic [8:0]  hc,
    output logic [8:0]  vc,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        disp_en,
    output logic        int_n,
    output logic        flash,
    output logic [12:0] bmp_addr,
    output logic [12:0] att_addr
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] HS_FIRST = 9'(HS_START);
    localparam logic [8:0] HS_LAST  = 9'(HS_END);
    localparam logic [8:0] INT_CNT  = 9'(INT_LEN);

    logic [4:0]  frame;

    logic [8:0]  hc_nxt;
    logic [8:0]  vc_nxt;
    logic [4:0]  frame_nxt;
    logic        h_wrap;
    logic        v_wrap;

    logic        hsync_n_nxt;
    logic        vsync_n_nxt;
    logic        blank_nxt;
    logic        disp_en_nxt;
    logic        int_n_nxt;
    logic [12:0] bmp_addr_nxt;
    logic [12:0] att_addr_nxt;

    // Next counter values. Reset and hold are folded in here so that every
    // output register below is simply a decode of the next counter state; this
    // keeps the outputs aligned with hc/vc in the same cycle.
    always_comb begin
        h_wrap    = (hc == H_LAST);
        v_wrap    = (vc == V_LAST);
        hc_nxt    = hc;
        vc_nxt    = vc;
        frame_nxt = frame;
        if (reset) begin
            hc_nxt    = '0;
            vc_nxt    = '0;
            frame_nxt = '0;
        end else if (ce) begin
            hc_nxt = h_wrap ? 9'd0 : hc + 9'd1;
            if (h_wrap) begin
                vc_nxt = v_wrap ? 9'd0 : vc + 9'd1;
                if (v_wrap) begin
                    frame_nxt = frame + 5'd1;
                end
            end
        end
    end

    always_comb begin
        disp_en_nxt  = (hc_nxt < 9'd256) && (vc_nxt < 9'd192);
        hsync_n_nxt  = !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
        vsync_n_nxt  = !((vc_nxt >= 9'd248) && (vc_nxt <= 9'd251));
        blank_nxt    = ((hc_nxt >= 9'd312) && (hc_nxt <= 9'd415)) ||
                       ((vc_nxt >= 9'd248) && (vc_nxt <= 9'd255));
        // A reset during the pulse lands on vc=0, so int_n is released there.
        int_n_nxt    = !((vc_nxt == 9'd248) && (hc_nxt < INT_CNT));
        // Screen thirds / pixel row within char / char row, then column.
        bmp_addr_nxt = {vc_nxt[7:6], vc_nxt[2:0], vc_nxt[5:3], hc_nxt[7:3]};
        att_addr_nxt = {3'b110, vc_nxt[7:3], hc_nxt[7:3]};
    end

    always_ff @(negedge clock) begin
        hc       <= hc_nxt;
        vc       <= vc_nxt;
        frame    <= frame_nxt;
        hsync_n  <= hsync_n_nxt;
        vsync_n  <= vsync_n_nxt;
        blank    <= blank_nxt;
        disp_en  <= disp_en_nxt;
        int_n    <= int_n_nxt;
        flash    <= frame_nxt[4];
        bmp_addr <= bmp_addr_nxt;
        att_addr <= att_addr_nxt;
    end

endmodule

// File: tb/tb_ula_video_timing.sv
// Testbench for ula_video_timing. Four instances share one clock:
//   0: full 448x312 geometry (horizontal decodes, line wrap)
//   1: 256x256 geometry (reaches the active-area corner and line 248 quickly)
//   2: 4x4 geometry (frame counter / FLASH over 32 frames)
//   3: 80x256 geometry with its own reset/ce (reset during INT, ce hold)
// A pixel-count model predicts every output of every instance each cycle.

module tb_ula_video_timing;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_m, ce_m, reset_d, ce_d;

    logic [8:0]  hc   [4];
    logic [8:0]  vc   [4];
    logic        hs   [4];
    logic        vs   [4];
    logic        bl   [4];
    logic        de   [4];
    logic        intn [4];
    logic        fl   [4];
    logic [12:0] bmp  [4];
    logic [12:0] att  [4];

    ula_video_timing u_a (
        .clock(clock), .reset(reset_m), .ce(ce_m),
        .hc(hc[0]), .vc(vc[0]), .hsync_n(hs[0]), .vsync_n(vs[0]), .blank(bl[0]),
        .disp_en(de[0]), .int_n(intn[0]), .flash(fl[0]), .bmp_addr(bmp[0]), .att_addr(att[0])
    );

    ula_video_timing #(.H_TOTAL(256), .V_TOTAL(256)) u_b (
        .clock(clock), .reset(reset_m), .ce(ce_m),
        .hc(hc[1]), .vc(vc[1]), .hsync_n(hs[1]), .vsync_n(vs[1]), .blank(bl[1]),
        .disp_en(de[1]), .int_n(intn[1]), .flash(fl[1]), .bmp_addr(bmp[1]), .att_addr(att[1])
    );

    ula_video_timing #(.H_TOTAL(4), .V_TOTAL(4)) u_c (
        .clock(clock), .reset(reset_m), .ce(ce_m),
        .hc(hc[2]), .vc(vc[2]), .hsync_n(hs[2]), .vsync_n(vs[2]), .blank(bl[2]),
        .disp_en(de[2]), .int_n(intn[2]), .flash(fl[2]), .bmp_addr(bmp[2]), .att_addr(att[2])
    );

    ula_video_timing #(.H_TOTAL(80), .V_TOTAL(256)) u_d (
        .clock(clock), .reset(reset_d), .ce(ce_d),
        .hc(hc[3]), .vc(vc[3]), .hsync_n(hs[3]), .vsync_n(vs[3]), .blank(bl[3]),
        .disp_en(de[3]), .int_n(intn[3]), .flash(fl[3]), .bmp_addr(bmp[3]), .att_addr(att[3])
    );

    int errors = 0;
    int checks = 0;
    int cur    = 0;

    // Model: each instance is just a count of pixel clocks since reset.
    longint H   [4] = '{448, 256, 4, 80};
    longint V   [4] = '{312, 256, 4, 256};
    longint cnt [4];
    bit     valid [4] = '{0, 0, 0, 0};

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            logic r, c;
            r = (i == 3) ? reset_d : reset_m;
            c = (i == 3) ? ce_d : ce_m;
            if (r) begin
                cnt[i]   <= 0;
                valid[i] <= 1'b1;
            end else if (c) begin
                cnt[i] <= cnt[i] + 1;
            end
        end
    end

    task automatic check_inst(input int i);
        longint p;
        int h, v, f, x, y;
        logic e_hs, e_vs, e_bl, e_de, e_in, e_fl;
        logic [12:0] e_bmp, e_att;
        logic [49:0] ev, av;
        p = cnt[i];
        h = int'(p % H[i]);
        v = int'((p / H[i]) % V[i]);
        f = int'((p / (H[i] * V[i])) % 32);
        x = h % 256;
        y = v % 256;
        e_de  = (h < 256) && (v < 192);
        e_hs  = !(h >= 320 && h <= 351);
        e_vs  = !(v >= 248 && v <= 251);
        e_bl  = (h >= 312 && h <= 415) || (v >= 248 && v <= 255);
        e_in  = !(v == 248 && h < 64);
        e_fl  = (f >= 16);
        e_bmp = 13'((y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x / 8);
        e_att = 13'(6144 + (y / 8) * 32 + x / 8);
        ev = {9'(h), 9'(v), e_hs, e_vs, e_bl, e_de, e_in, e_fl,
              e_de ? e_bmp : 13'd0, e_de ? e_att : 13'd0};
        av = {hc[i], vc[i], hs[i], vs[i], bl[i], de[i], intn[i], fl[i],
              e_de ? bmp[i] : 13'd0, e_de ? att[i] : 13'd0};
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL model inst=%0d t=%0t got=%h want=%h (hc vc hs vs bl de int fl bmp att)",
                     i, $time, av, ev);
        end
    endtask

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (valid[i]) check_inst(i);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic goto(input int target);
        while (cur < target) begin
            @(posedge clock);
            cur++;
        end
    endtask

    initial begin
        reset_m = 1'b1; ce_m = 1'b1;
        reset_d = 1'b1; ce_d = 1'b1;
        @(negedge clock);
        @(posedge clock);
        reset_m = 1'b0;
        reset_d = 1'b0;
        cur = 0;
        lit("a_reset_hc",   32'(hc[0]), 0);
        lit("a_reset_att",  32'(att[0]), 32'h1800);
        lit("a_reset_bl",   32'(bl[0]), 0);

        goto(2);
        lit("a_hc_2",    32'(hc[0]), 2);
        lit("a_vc_2",    32'(vc[0]), 0);
        lit("a_de_2",    32'(de[0]), 1);
        lit("a_int_2",   32'(intn[0]), 1);
        lit("a_bmp_2",   32'(bmp[0]), 32'h0000);
        lit("a_att_2",   32'(att[0]), 32'h1800);

        goto(255);
        lit("c_flash_255", 32'(fl[2]), 0);
        goto(256);
        lit("c_flash_256", 32'(fl[2]), 1);
        lit("c_hc_256",    32'(hc[2]), 0);
        lit("a_de_256",    32'(de[0]), 0);
        goto(312);
        lit("a_blank_312", 32'(bl[0]), 1);
        goto(320);
        lit("a_hs_320",    32'(hs[0]), 0);
        goto(351);
        lit("a_hs_351",    32'(hs[0]), 0);
        goto(352);
        lit("a_hs_352",    32'(hs[0]), 1);
        goto(415);
        lit("a_blank_415", 32'(bl[0]), 1);
        goto(416);
        lit("a_blank_416", 32'(bl[0]), 0);
        goto(447);
        lit("a_hc_447",    32'(hc[0]), 447);
        lit("a_vc_447",    32'(vc[0]), 0);
        goto(448);
        lit("a_hc_wrap",   32'(hc[0]), 0);
        lit("a_vc_wrap",   32'(vc[0]), 1);
        lit("a_bmp_wrap",  32'(bmp[0]), 32'h0100);
        lit("a_flash_wrap", 32'(fl[0]), 0);
        goto(511);
        lit("c_flash_511", 32'(fl[2]), 1);
        goto(512);
        lit("c_flash_512", 32'(fl[2]), 0);

        goto(19850);
        lit("d_hc_pre",  32'(hc[3]), 10);
        lit("d_vc_pre",  32'(vc[3]), 248);
        lit("d_int_pre", 32'(intn[3]), 0);
        reset_d = 1'b1;
        goto(19851);
        lit("d_hc_rst",  32'(hc[3]), 0);
        lit("d_vc_rst",  32'(vc[3]), 0);
        lit("d_int_rst", 32'(intn[3]), 1);
        reset_d = 1'b0;
        goto(19871);
        lit("d_hc_run",  32'(hc[3]), 20);
        ce_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            goto(cur + 1);
            lit("d_hc_hold", 32'(hc[3]), 20);
        end
        ce_d = 1'b1;
        goto(cur + 1);
        lit("d_hc_resume", 32'(hc[3]), 21);

        goto(49151);
        lit("b_hc_corner",  32'(hc[1]), 255);
        lit("b_vc_corner",  32'(vc[1]), 191);
        lit("b_bmp_corner", 32'(bmp[1]), 32'h17FF);
        lit("b_att_corner", 32'(att[1]), 32'h1AFF);
        lit("b_de_corner",  32'(de[1]), 1);
        goto(49152);
        lit("b_de_after",   32'(de[1]), 0);

        goto(63487);
        lit("b_int_before", 32'(intn[1]), 1);
        goto(63488);
        lit("b_vc_248",     32'(vc[1]), 248);
        lit("b_int_fall",   32'(intn[1]), 0);
        lit("b_vs_248",     32'(vs[1]), 0);
        lit("b_bl_248",     32'(bl[1]), 1);
        goto(63551);
        lit("b_int_63",     32'(intn[1]), 0);
        goto(63552);
        lit("b_hc_64",      32'(hc[1]), 64);
        lit("b_int_rise",   32'(intn[1]), 1);
        goto(64511);
        lit("b_vs_251",     32'(vs[1]), 0);
        goto(64512);
        lit("b_vs_252",     32'(vs[1]), 1);
        lit("b_bl_252",     32'(bl[1]), 1);
        goto(65535);
        lit("b_bl_255",     32'(bl[1]), 1);
        goto(65536);
        lit("b_vc_wrap",    32'(vc[1]), 0);
        lit("b_bl_wrap",    32'(bl[1]), 0);
        lit("b_flash_1f",   32'(fl[1]), 0);

        goto(65540);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
